game_round_ctrl: RTL and testbench
==================================

Name: game_round_ctrl

Overview:
Round sequencer for the memorization game. It fetches a challenge from the sequence provider over a req/ack handshake and times the on-screen display window by difficulty. It then checks keypad digits one at a time, MSB nibble first, against the latched challenge. It reports pass or fail to the top-level game FSM, which keeps score and game-over state, and it drives the VGA show_number and num_string inputs.

Parameters:
DIGITS, 4, number of hex digits per challenge; sequence width is 4*DIGITS
T_EASY, 7000000, display window in clk cycles for difficulty 2'b00
T_MEDIUM, 5000000, display window for 2'b01
T_HARD, 3000000, display window for 2'b10 and 2'b11
T_INPUT, 300000000, input timeout in cycles, restarted on each accepted key (only with ROUND_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a round; ignored unless in IDLE
abort  input  1  synchronous; returns to IDLE from any state with no result pulse
difficulty  input  2  sampled on the accepted start pulse
seq_req  output  1  request to the sequence provider
seq_ack  input  1  provider ack; seq_data is valid in the same cycle
seq_data  input  4*DIGITS  challenge from the provider
key_valid  input  1  one-cycle pulse per debounced key press
key_value  input  4  key code, valid while key_valid is high
show_number  output  1  high during the display window
shown_sequence  output  4*DIGITS  latched challenge, drives num_string
busy  output  1  high in every state except IDLE
digit_idx  output  $clog2(DIGITS+1)  count of correct digits entered this round
round_pass  output  1  one-cycle pulse
round_fail  output  1  one-cycle pulse
fail_cause  output  2  00 none, 01 mismatch, 10 timeout; holds until the next accepted start

Behaviour:
- Reset: state IDLE; all outputs 0, including shown_sequence and fail_cause.
- States: IDLE, FETCH, SHOW, INPUT, RESULT.
- IDLE: on start, latch difficulty, clear digit_idx and fail_cause, go to FETCH.
- FETCH:
  - seq_req is a registered output and stays high until the ack cycle.
  - When seq_ack=1: latch seq_data into shown_sequence, load the display timer, go to SHOW.
  - seq_req is 0 in the cycle after the ack. No timeout in FETCH.
- SHOW:
  - show_number=1 for exactly T_x cycles. The timer loads T_x-1 and counts down; leave at 0 and enter INPUT.
  - key_valid is ignored.
- INPUT:
  - The expected nibble is shown_sequence[4*(DIGITS-digit_idx)-1 -: 4].
  - key_valid with key equal to the expected nibble: digit_idx+1. If digit_idx reaches DIGITS, set the pass flag and go to RESULT.
  - key_valid with any other key: fail_cause=01, go to RESULT.
  - Keys are not decoded specially; 0xF is compared like any other nibble.
- RESULT:
  - Exactly one cycle. Pulse round_pass or round_fail, whichever was flagged, then go to IDLE.
  - Pulses are registered and occur in the RESULT cycle.
- abort: highest priority after rst.
  - Any state goes to IDLE next cycle; seq_req and show_number drop.
  - No pulse; fail_cause and digit_idx hold.
- start outside IDLE: ignored. start coincident with abort: abort wins and the start is dropped.
- shown_sequence holds its value after the round, for debug and score display.
- Latency: start to seq_req is 1 cycle. The last correct key to round_pass is 1 cycle.

Optional Feature:
ROUND_TIMEOUT_EN
- Defined:
  - The input timer loads T_INPUT-1 on INPUT entry and on every accepted key, and counts down each cycle in INPUT.
  - Reaching 0 with no key_valid sets fail_cause=10 and goes to RESULT.
  - key_valid in the expiry cycle takes priority and is evaluated normally.
- Undefined:
  - No input timer is instantiated; INPUT waits indefinitely.
  - fail_cause=10 never occurs.

Test Plan:
- Pass round (T_EASY overridden to 20): start, diff=00, ack seq_data=16'h3A7F one cycle after seq_req. Required:
  - show_number high exactly 20 cycles.
  - Keys 3, A, 7, F give digit_idx 1..4.
  - round_pass pulses once, 1 cycle after key F; busy then falls.
- Mismatch: seq 16'h1234, keys 1, 5. Required:
  - round_fail pulses after key 5, fail_cause=01, digit_idx=1.
- Handshake hold: delay seq_ack 10 cycles. Required:
  - seq_req high for all 10 waiting cycles and low the cycle after ack.
  - Keys pressed during FETCH and SHOW are ignored; digit_idx stays 0.
- Difficulty: diff=11 with T_HARD=8. Required: show_number lasts 8 cycles. Also, start during SHOW has no effect.
- Abort: abort in INPUT after 2 correct digits. Required: IDLE next cycle, no pulses, digit_idx stays 2, and a new start then proceeds normally.
- Timeout (ROUND_TIMEOUT_EN, T_INPUT=50):
  - No key for 50 cycles in INPUT: round_fail pulses, fail_cause=10.
  - Key arriving exactly on the expiry cycle: accepted, no fail.

Source files
------------

// File: rtl/game_round_ctrl.sv
// Round sequencer: fetches a challenge, times its display by difficulty, then checks keyed digits.
// Optional input timeout is enabled by defining ROUND_TIMEOUT_EN.
module game_round_ctrl #(
  parameter int DIGITS   = 4,
  parameter int T_EASY   = 7000000,
  parameter int T_MEDIUM = 5000000,
  parameter int T_HARD   = 3000000,
  parameter int T_INPUT  = 300000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [1:0]                   difficulty,
  output logic                         seq_req,
  input  logic                         seq_ack,
  input  logic [4*DIGITS-1:0]          seq_data,
  input  logic                         key_valid,
  input  logic [3:0]                   key_value,
  output logic                         show_number,
  output logic [4*DIGITS-1:0]          shown_sequence,
  output logic                         busy,
  output logic [$clog2(DIGITS+1)-1:0]  digit_idx,
  output logic                         round_pass,
  output logic                         round_fail,
  output logic [1:0]                   fail_cause
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | seq_req high until the provider acks
  // SHOW   | challenge on screen, display timer running
  // INPUT  | comparing keyed digits, MSB nibble first
  // RESULT | one cycle carrying the pass/fail pulse

  localparam int IW = $clog2(DIGITS + 1);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared down-counter serves both the display and input windows.
  localparam int T_MAX = max2(max2(T_EASY, T_MEDIUM), max2(T_HARD, T_INPUT));
  localparam int TW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHOW, INPUT, RESULT} state_t;

  state_t        state;
  logic [1:0]    level;
  logic [TW-1:0] timer;
  logic [3:0]    want_nibble;

  function automatic logic [TW-1:0] show_load(input logic [1:0] d);
    case (d)
      2'b00:   return TW'(T_EASY - 1);
      2'b01:   return TW'(T_MEDIUM - 1);
      default: return TW'(T_HARD - 1);
    endcase
  endfunction

  always_comb begin
    want_nibble = '0;
    for (int i = 0; i < DIGITS; i++)
      if (digit_idx == IW'(i)) want_nibble = shown_sequence[4*(DIGITS-i)-1 -: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      level          <= 2'b00;
      timer          <= '0;
      seq_req        <= 1'b0;
      show_number    <= 1'b0;
      shown_sequence <= '0;
      busy           <= 1'b0;
      digit_idx      <= '0;
      round_pass     <= 1'b0;
      round_fail     <= 1'b0;
      fail_cause     <= 2'b00;
    end else begin
      round_pass <= 1'b0;
      round_fail <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        seq_req     <= 1'b0;
        show_number <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              level      <= difficulty;
              digit_idx  <= '0;
              fail_cause <= 2'b00;
              seq_req    <= 1'b1;
              busy       <= 1'b1;
              state      <= FETCH;
            end
          end
          FETCH: begin
            if (seq_ack) begin
              shown_sequence <= seq_data;
              timer          <= show_load(level);
              seq_req        <= 1'b0;
              show_number    <= 1'b1;
              state          <= SHOW;
            end
          end
          SHOW: begin
            if (timer == '0) begin
              show_number <= 1'b0;
              state       <= INPUT;
`ifdef ROUND_TIMEOUT_EN
              timer       <= TW'(T_INPUT - 1);
`endif
            end else begin
              timer <= timer - TW'(1);
            end
          end
          INPUT: begin
            if (key_valid) begin
              if (key_value == want_nibble) begin
                digit_idx <= digit_idx + IW'(1);
`ifdef ROUND_TIMEOUT_EN
                timer     <= TW'(T_INPUT - 1);
`endif
                if (digit_idx == IW'(DIGITS - 1)) begin
                  round_pass <= 1'b1;
                  state      <= RESULT;
                end
              end else begin
                fail_cause <= 2'b01;
                round_fail <= 1'b1;
                state      <= RESULT;
              end
            end
`ifdef ROUND_TIMEOUT_EN
            else if (timer == '0) begin
              fail_cause <= 2'b10;
              round_fail <= 1'b1;
              state      <= RESULT;
            end else begin
              timer <= timer - TW'(1);
            end
`endif
          end
          RESULT: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed rounds from the test plan plus randomized rounds
// judged by a round-level model (nibble-by-nibble walk of the challenge).
module tb_game_round_ctrl;

  localparam int DIGITS   = 4;
  localparam int T_EASY   = 20;
  localparam int T_MEDIUM = 14;
  localparam int T_HARD   = 8;
  localparam int T_INPUT  = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  difficulty;
  logic        seq_req;
  logic        seq_ack;
  logic [15:0] seq_data;
  logic        key_valid;
  logic [3:0]  key_value;
  logic        show_number;
  logic [15:0] shown_sequence;
  logic        busy;
  logic [2:0]  digit_idx;
  logic        round_pass;
  logic        round_fail;
  logic [1:0]  fail_cause;

  int n_checks = 0;
  int n_errors = 0;

  game_round_ctrl #(
    .DIGITS(DIGITS), .T_EASY(T_EASY), .T_MEDIUM(T_MEDIUM), .T_HARD(T_HARD), .T_INPUT(T_INPUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .difficulty(difficulty),
    .seq_req(seq_req), .seq_ack(seq_ack), .seq_data(seq_data),
    .key_valid(key_valid), .key_value(key_value),
    .show_number(show_number), .shown_sequence(shown_sequence), .busy(busy),
    .digit_idx(digit_idx), .round_pass(round_pass), .round_fail(round_fail),
    .fail_cause(fail_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int show_len(input logic [1:0] d);
    if (d == 2'b00) return T_EASY;
    if (d == 2'b01) return T_MEDIUM;
    return T_HARD;
  endfunction

  task automatic do_start(input logic [1:0] d);
    start = 1'b1;
    difficulty = d;
    tick();
    start = 1'b0;
    difficulty = 2'($urandom);
    check("start_seq_req", seq_req, 1);
    check("start_busy", busy, 1);
    check("start_idx", digit_idx, 0);
    check("start_cause", fail_cause, 0);
  endtask

  task automatic do_fetch(input logic [15:0] seq, input int delay, input bit noise);
    for (int i = 0; i < delay; i++) begin
      key_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      key_value = 4'($urandom);
      tick();
      check("seq_req_hold", seq_req, 1);
    end
    key_valid = 1'b0;
    seq_ack = 1'b1;
    seq_data = seq;
    tick();
    seq_ack = 1'b0;
    seq_data = 16'($urandom);
    check("seq_req_drop", seq_req, 0);
    check("show_on", show_number, 1);
    check("latched_seq", shown_sequence, seq);
    check("idx_fetch", digit_idx, 0);
  endtask

  task automatic do_show(input logic [1:0] d, input bit noise);
    int cnt;
    cnt = 0;
    while (show_number && cnt < 1000) begin
      key_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      key_value = 4'($urandom);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cnt++;
      tick();
    end
    key_valid = 1'b0;
    start = 1'b0;
    check("show_len", cnt, show_len(d));
    check("idx_after_show", digit_idx, 0);
    check("busy_input", busy, 1);
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_value = k;
    tick();
    key_valid = 1'b0;
    key_value = 4'($urandom);
  endtask

  task automatic do_abort(input int exp_idx);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_seq_req", seq_req, 0);
    check("abort_show", show_number, 0);
    check("abort_pass", round_pass, 0);
    check("abort_fail", round_fail, 0);
    check("abort_idx", digit_idx, exp_idx);
    tick();
    check("abort_no_late_pulse", {round_pass, round_fail}, 0);
  endtask

  // Reference: walk keys against challenge nibbles MSB first; first mismatch fails, all match passes.
  task automatic run_round(input logic [15:0] seq, input logic [1:0] d, input int delay,
                           input bit noise, input logic [15:0] keys, input int abort_at);
    logic [3:0] want;
    logic [3:0] k;
    do_start(d);
    do_fetch(seq, delay, noise);
    do_show(d, noise);
    for (int i = 0; i < DIGITS; i++) begin
      want = seq[4*(DIGITS-1-i) +: 4];
      k = keys[4*(DIGITS-1-i) +: 4];
      if (abort_at == i) begin
        do_abort(i);
        return;
      end
      repeat ($urandom_range(0, 3)) tick();
      press(k);
      if (k == want) begin
        if (i == DIGITS - 1) begin
          check("pass_pulse", round_pass, 1);
          check("pass_no_fail", round_fail, 0);
          check("pass_idx", digit_idx, DIGITS);
          check("pass_cause", fail_cause, 0);
          tick();
          check("pass_once", round_pass, 0);
          check("pass_busy_low", busy, 0);
          return;
        end
        check("key_idx", digit_idx, i + 1);
        check("key_no_pulse", {round_pass, round_fail}, 0);
      end else begin
        check("fail_pulse", round_fail, 1);
        check("fail_no_pass", round_pass, 0);
        check("fail_cause_mm", fail_cause, 1);
        check("fail_idx", digit_idx, i);
        tick();
        check("fail_once", round_fail, 0);
        check("fail_busy_low", busy, 0);
        return;
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq;
    logic [15:0] keys;
    logic [3:0]  nib;
    int          abort_at;
    int          cnt;

    rst = 1'b1; start = 1'b0; abort = 1'b0; difficulty = 2'b00;
    seq_ack = 1'b0; seq_data = 16'hFFFF; key_valid = 1'b0; key_value = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {seq_req, show_number, busy, digit_idx, round_pass, round_fail, fail_cause}, 0);
    check("rst_shown", shown_sequence, 0);
    rst = 1'b0;
    tick();

    // Pass round, easy
    run_round(16'h3A7F, 2'b00, 1, 1'b0, 16'h3A7F, -1);
    // Mismatch on second key; cause holds while idle
    run_round(16'h1234, 2'b01, 0, 1'b0, 16'h1500, -1);
    repeat (5) tick();
    check("cause_hold", fail_cause, 1);
    check("seq_hold", shown_sequence, 16'h1234);
    // Delayed ack with keys during FETCH/SHOW
    run_round(16'hBEEF, 2'b00, 10, 1'b1, 16'hBEEF, -1);
    // Hard difficulty (2'b11) with start pulses during SHOW
    run_round(16'h0F0F, 2'b11, 2, 1'b1, 16'h0F0F, -1);
    // Abort after two correct digits, then a clean round
    run_round(16'h9C41, 2'b10, 1, 1'b0, 16'h9C41, 2);
    run_round(16'hFFFF, 2'b10, 0, 1'b0, 16'hFFFF, -1);

    // Abort during FETCH
    do_start(2'b00);
    tick();
    do_abort(0);
    // start coincident with abort is dropped
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_req", seq_req, 0);

`ifdef ROUND_TIMEOUT_EN
    do_start(2'b10);
    do_fetch(16'hC0DE, 0, 1'b0);
    do_show(2'b10, 1'b0);
    cnt = 0;
    while (!round_fail && cnt < 200) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", cnt, T_INPUT);
    check("timeout_cause", fail_cause, 2);
    check("timeout_idx", digit_idx, 0);
    tick();
    check("timeout_busy_low", busy, 0);

    do_start(2'b10);
    do_fetch(16'h5A5A, 0, 1'b0);
    do_show(2'b10, 1'b0);
    press(4'h5);
    check("expiry_first_key", digit_idx, 1);
    repeat (T_INPUT - 1) tick();
    check("expiry_still_waiting", {busy, round_fail}, 2'b10);
    press(4'hA);
    check("expiry_key_idx", digit_idx, 2);
    check("expiry_key_no_fail", round_fail, 0);
    press(4'h5);
    press(4'hA);
    check("expiry_round_pass", round_pass, 1);
    tick();
`else
    do_start(2'b10);
    do_fetch(16'hC0DE, 0, 1'b0);
    do_show(2'b10, 1'b0);
    repeat (200) tick();
    check("no_timeout_busy", busy, 1);
    check("no_timeout_cause", fail_cause, 0);
    press(4'hC); press(4'h0); press(4'hD); press(4'hE);
    check("no_timeout_pass", round_pass, 1);
    tick();
`endif

    for (int r = 0; r < 40; r++) begin
      seq = 16'($urandom);
      keys = seq;
      for (int i = 0; i < DIGITS; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          nib = seq[4*i +: 4] ^ 4'($urandom_range(1, 15));
          keys[4*i +: 4] = nib;
        end
      end
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_round(seq, 2'($urandom), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), keys, abort_at);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
